// File: rtl/btn_event_arbiter.sv
// Push-button front end: 2-flop sync, per-button debounce, pending latch, round-robin event port.
// Optional BTN_RELEASE_EVT_EN adds release events (evt_release=1) alongside presses.
module btn_event_arbiter #(
    parameter  int unsigned N_BTN           = 4,
    parameter  int unsigned DEBOUNCE_CYCLES = 16,
    localparam int unsigned IDX_W           = $clog2(N_BTN)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_release,
    input  logic             evt_ready,
    output logic [N_BTN-1:0] btn_state,
    output logic             overrun
);

`ifdef BTN_RELEASE_EVT_EN
    localparam int unsigned REQ_N = 2 * N_BTN;
`else
    localparam int unsigned REQ_N = N_BTN;
`endif
    localparam int unsigned GW    = $clog2(REQ_N);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic {ST_IDLE, ST_HOLD} state_e;

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] bst_q, bst_d, prev_q;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] press_q, press_d, rise;
    logic [REQ_N-1:0] req, clr;
    logic [GW-1:0]    rr_q, rr_d, gpos;
    logic [GW:0]      pk;
    logic             load;
    state_e           st_q, st_d;
    logic             valid_q, valid_d, rflag_q, rflag_d, ovr_q, ovr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
`ifdef BTN_RELEASE_EVT_EN
    logic [N_BTN-1:0] relp_q, relp_d, fall;
`endif

    // First set request at or after ptr, wrapping; returns {found, index}.
    function automatic logic [GW:0] rr_pick(input logic [REQ_N-1:0] r, input logic [GW-1:0] ptr);
        logic          found;
        logic [GW-1:0] sel;
        int unsigned   j;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < REQ_N; k++) begin
            j = 32'(ptr) + k;
            if (j >= REQ_N) j = j - REQ_N;
            if (!found && r[GW'(j)]) begin
                found = 1'b1;
                sel   = GW'(j);
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
        return (32'(g) == REQ_N - 1) ? '0 : g + 1'b1;
    endfunction

    // Debounce counters and pending-request bookkeeping.
    always_comb begin
        bst_d = bst_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == bst_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                bst_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        rise    = bst_q & ~prev_q;
        press_d = (press_q & ~clr[N_BTN-1:0]) | rise;
        ovr_d   = |(rise & press_q & ~clr[N_BTN-1:0]);
`ifdef BTN_RELEASE_EVT_EN
        fall   = ~bst_q & prev_q;
        relp_d = (relp_q & ~clr[REQ_N-1:N_BTN]) | fall;
        ovr_d  = ovr_d | (|(fall & relp_q & ~clr[REQ_N-1:N_BTN]));
`endif
    end

`ifdef BTN_RELEASE_EVT_EN
    assign req  = {relp_q, press_q};
    assign gpos = rflag_q ? GW'(N_BTN) + GW'(idx_q) : GW'(idx_q);
`else
    assign req  = press_q;
    assign gpos = GW'(idx_q);
`endif

    // Arbiter FSM: next state, grant load and pending clear.
    always_comb begin
        st_d    = st_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        rflag_d = rflag_q;
        rr_d    = rr_q;
        clr     = '0;
        pk      = '0;
        load    = 1'b0;
        case (st_q)
            ST_IDLE: begin
                pk = rr_pick(req, rr_q);
                if (pk[GW]) begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                    st_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (evt_ready) begin
                    clr  = REQ_N'(1) << gpos;
                    rr_d = rr_next(gpos);
                    pk   = rr_pick(req & ~clr, rr_d);
                    if (pk[GW]) begin
                        load = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        st_d    = ST_IDLE;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
        if (load) begin
`ifdef BTN_RELEASE_EVT_EN
            if (pk[GW-1:0] >= GW'(N_BTN)) begin
                rflag_d = 1'b1;
                idx_d   = IDX_W'(pk[GW-1:0] - GW'(N_BTN));
            end else begin
                rflag_d = 1'b0;
                idx_d   = IDX_W'(pk[GW-1:0]);
            end
`else
            rflag_d = 1'b0;
            idx_d   = IDX_W'(pk[GW-1:0]);
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            bst_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '{default: '0};
            press_q <= '0;
            rr_q    <= '0;
            st_q    <= ST_IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            rflag_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef BTN_RELEASE_EVT_EN
            relp_q  <= '0;
`endif
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            bst_q   <= bst_d;
            prev_q  <= bst_q;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rr_q    <= rr_d;
            st_q    <= st_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            rflag_q <= rflag_d;
            ovr_q   <= ovr_d;
`ifdef BTN_RELEASE_EVT_EN
            relp_q  <= relp_d;
`endif
        end
    end

    assign evt_valid   = valid_q;
    assign evt_idx     = idx_q;
    assign evt_release = rflag_q;
    assign btn_state   = bst_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter (N_BTN=4, DEBOUNCE_CYCLES=16); honours BTN_RELEASE_EVT_EN.
module tb_btn_event_arbiter;

`ifdef BTN_RELEASE_EVT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] btn_in;
    logic       evt_valid;
    logic [1:0] evt_idx;
    logic       evt_release;
    logic       evt_ready;
    logic [3:0] btn_state;
    logic       overrun;

    btn_event_arbiter #(.N_BTN(4), .DEBOUNCE_CYCLES(16)) dut (
        .Clk(Clk), .Reset(Reset), .btn_in(btn_in),
        .evt_valid(evt_valid), .evt_idx(evt_idx), .evt_release(evt_release),
        .evt_ready(evt_ready), .btn_state(btn_state), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        int         cyc;
        logic       rel;
        logic [1:0] idx;
    } ev_t;

    typedef struct {
        logic [3:0] btn;
        int         hi;
        int         n_press;
        logic [1:0] idx;
        logic [3:0] seen;
    } vec_t;

    ev_t  evq[$];
    ev_t  exp_q[$];
    int   cyc = 0;
    int   ov_cnt = 0;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] seen_state;
    logic seen_valid, seen_ovr;

    // Handshake and overrun logger.
    always @(negedge Clk) begin
        cyc <= cyc + 1;
        if (!Reset && evt_valid && evt_ready)
            evq.push_back('{cyc: cyc, rel: evt_release, idx: evt_idx});
        if (overrun) ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge Clk); #1;
            seen_state |= btn_state;
            seen_valid |= evt_valid;
            seen_ovr   |= overrun;
        end
    endtask

    task automatic clear_seen();
        seen_state = '0;
        seen_valid = 1'b0;
        seen_ovr   = 1'b0;
    endtask

    task automatic add_exp(input logic [1:0] idx, input logic rel);
        exp_q.push_back('{cyc: 0, rel: rel, idx: idx});
    endtask

    task automatic cmp_evs(input string nm, input int base);
        chk($sformatf("%s_count", nm), 32'(evq.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < evq.size(); i++) begin
            chk($sformatf("%s_idx%0d", nm, i), 32'(evq[base+i].idx), 32'(exp_q[i].idx));
            chk($sformatf("%s_rel%0d", nm, i), 32'(evq[base+i].rel), 32'(exp_q[i].rel));
        end
        exp_q.delete();
    endtask

    vec_t vecs[5];

    initial begin
        int base, ov0, bad;
        vecs[0] = '{btn: 4'b0010, hi: 10, n_press: 0, idx: 2'd0, seen: 4'b0000};
        vecs[1] = '{btn: 4'b0010, hi: 15, n_press: 0, idx: 2'd0, seen: 4'b0000};
        vecs[2] = '{btn: 4'b0010, hi: 16, n_press: 1, idx: 2'd1, seen: 4'b0010};
        vecs[3] = '{btn: 4'b1000, hi: 30, n_press: 1, idx: 2'd3, seen: 4'b1000};
        vecs[4] = '{btn: 4'b0001, hi: 2,  n_press: 0, idx: 2'd0, seen: 4'b0000};

        Reset = 1'b1; btn_in = '0; evt_ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_idx", 32'(evt_idx), 0);
        chk("rst_release", 32'(evt_release), 0);
        chk("rst_state", 32'(btn_state), 0);
        chk("rst_overrun", 32'(overrun), 0);

        // Quiet inputs, ready high: nothing may happen.
        evt_ready = 1'b1;
        clear_seen();
        run(100);
        chk("idle_valid", 32'(seen_valid), 0);
        chk("idle_state", 32'(seen_state), 0);
        chk("idle_overrun", 32'(seen_ovr), 0);

        // Latency: btn_in driven after edge 0.
        base = evq.size();
        btn_in = 4'b0100;
        for (int k = 1; k <= 21; k++) begin
            @(posedge Clk); #1;
            if (k == 17) chk("lat_state_e17", 32'(btn_state[2]), 0);
            if (k == 18) chk("lat_state_e18", 32'(btn_state[2]), 1);
            if (k == 19) chk("lat_valid_e19", 32'(evt_valid), 0);
            if (k == 20) begin
                chk("lat_valid_e20", 32'(evt_valid), 1);
                chk("lat_idx_e20", 32'(evt_idx), 2);
            end
            if (k == 21) chk("lat_valid_e21", 32'(evt_valid), 0);
        end
        btn_in = '0;
        run(60);
        add_exp(2'd2, 1'b0);
        if (REL) add_exp(2'd2, 1'b1);
        cmp_evs("lat", base);

        // Glitch / pulse-width table.
        for (int v = 0; v < 5; v++) begin
            base = evq.size();
            clear_seen();
            btn_in = vecs[v].btn;
            run(vecs[v].hi);
            btn_in = '0;
            run(60);
            chk($sformatf("vec%0d_state", v), 32'(seen_state), 32'(vecs[v].seen));
            for (int n = 0; n < vecs[v].n_press; n++) begin
                add_exp(vecs[v].idx, 1'b0);
                if (REL) add_exp(vecs[v].idx, 1'b1);
            end
            cmp_evs($sformatf("vec%0d", v), base);
        end

        // Simultaneous presses of 0,1,3 held off by ready=0, then drained.
        evt_ready = 1'b0;
        base = evq.size();
        bad = 0;
        btn_in = 4'b1011;
        for (int k = 1; k <= 45; k++) begin
            @(posedge Clk); #1;
            if (k >= 20 && !(evt_valid === 1'b1 && evt_idx === 2'd0)) bad++;
        end
        chk("multi_hold_stable", 32'(bad), 0);
        evt_ready = 1'b1;
        run(10);
        chk("multi_gap01", 32'(evq[base+1].cyc - evq[base].cyc), 1);
        chk("multi_gap13", 32'(evq[base+2].cyc - evq[base+1].cyc), 1);
        add_exp(2'd0, 1'b0); add_exp(2'd1, 1'b0); add_exp(2'd3, 1'b0);
        cmp_evs("multi_press", base);
        base = evq.size();
        btn_in = '0;
        run(60);
        if (REL) begin
            add_exp(2'd0, 1'b1); add_exp(2'd1, 1'b1); add_exp(2'd3, 1'b1);
        end
        cmp_evs("multi_release", base);

        // Pointer wrap: 0 and 3 together after 3 was last granted.
        base = evq.size();
        btn_in = 4'b1001;
        run(40);
        btn_in = '0;
        run(60);
        add_exp(2'd0, 1'b0); add_exp(2'd3, 1'b0);
        if (REL) begin
            add_exp(2'd0, 1'b1); add_exp(2'd3, 1'b1);
        end
        cmp_evs("wrap", base);

        // Overrun: press, release, press again while the first press is unserved.
        evt_ready = 1'b0;
        base = evq.size();
        ov0 = ov_cnt;
        btn_in = 4'b0001; run(25);
        btn_in = 4'b0000; run(25);
        btn_in = 4'b0001; run(30);
        chk("ovr_pulses", 32'(ov_cnt - ov0), 1);
        chk("ovr_valid", 32'(evt_valid), 1);
        chk("ovr_idx", 32'(evt_idx), 0);
        evt_ready = 1'b1;
        run(10);
        add_exp(2'd0, 1'b0);
        if (REL) add_exp(2'd0, 1'b1);
        cmp_evs("ovr", base);
        btn_in = '0;
        run(60);

        // Reset while an event is held.
        evt_ready = 1'b0;
        btn_in = 4'b0100;
        run(25);
        chk("rsthold_valid_before", 32'(evt_valid), 1);
        chk("rsthold_idx_before", 32'(evt_idx), 2);
        Reset = 1'b1;
        btn_in = '0;
        base = evq.size();
        @(posedge Clk); #1;
        chk("rsthold_valid_after", 32'(evt_valid), 0);
        chk("rsthold_state_after", 32'(btn_state), 0);
        Reset = 1'b0;
        evt_ready = 1'b1;
        clear_seen();
        run(60);
        chk("rsthold_no_replay", 32'(seen_valid), 0);
        chk("rsthold_no_events", 32'(evq.size() - base), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
